// File: rtl/jtopl_pkg.sv
// Shared types and defaults for the jtopl host write queue.
package jtopl_pkg;

    localparam int ENTRY_W       = 9;
    localparam int DEF_ADDR_WAIT = 12;
    localparam int DEF_DATA_WAIT = 84;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT
    } wrq_state_t;

    typedef struct packed {
        logic       addr;
        logic [7:0] din;
    } wrq_entry_t;

endpackage

// File: rtl/jtopl_wrq_fifo.sv
// 2**AW x 9 write FIFO with flush; head entry is read straight from the read pointer.
module jtopl_wrq_fifo
    import jtopl_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  wrq_entry_t wr_data,
    output wrq_entry_t rd_data,
    output logic       full,
    output logic       empty,
    output logic [AW:0] level
);

    localparam int DEPTH = 2**AW;

    wrq_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    // A push into a full queue is lost even when a pop frees a slot on the same edge.
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/jtopl_wrq.sv
// Host write queue and OPL-paced replay onto the jtopl bus pins.
// Optional sticky overflow flag: define JTOPL_WRQ_OVF_EN.
module jtopl_wrq
    import jtopl_pkg::*;
#(
    parameter int AW        = 4,
    parameter int WAIT_W    = 8,
    parameter int ADDR_WAIT = DEF_ADDR_WAIT,
    parameter int DATA_WAIT = DEF_DATA_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [7:0]  host_din,
    input  logic        host_addr,
    input  logic        host_wr,
    input  logic        flush,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level,
    output logic        busy,
    output logic        ovf,
    output logic [7:0]  opl_din,
    output logic        opl_addr,
    output logic        opl_cs_n,
    output logic        opl_wr_n
);

    wrq_state_t        state;
    wrq_state_t        state_nx;
    wrq_entry_t        head;
    wrq_entry_t        wr_entry;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_load;
    logic              last_wait;
    logic              pop;
    logic              strobe;

    assign wr_entry = '{addr: host_addr, din: host_din};

    jtopl_wrq_fifo #(.AW(AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (host_wr),
        .pop     (pop),
        .flush   (flush),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign wait_load = opl_addr ? WAIT_W'(DATA_WAIT) : WAIT_W'(ADDR_WAIT);
    assign last_wait = (wait_cnt == WAIT_W'(1));

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    // The last wait period doubles as the next pop slot, so strobes land
    // exactly (wait + 1) cen periods apart when the queue stays non-empty.
    always_comb begin
        state_nx = state;
        if (cen) begin
            unique case (state)
                IDLE:    if (!empty) state_nx = STROBE;
                STROBE:  state_nx = (wait_load != '0) ? WAIT : IDLE;
                WAIT:    if (last_wait) state_nx = empty ? IDLE : STROBE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        pop    = 1'b0;
        strobe = 1'b0;
        unique case (state)
            IDLE:    pop = cen & ~empty;
            STROBE:  strobe = 1'b1;
            WAIT:    pop = cen & ~empty & last_wait;
            default: pop = 1'b0;
        endcase
    end

    assign opl_cs_n = ~strobe;
    assign opl_wr_n = ~strobe;
    assign busy     = (state != IDLE) | ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (cen) begin
            if (state == STROBE)    wait_cnt <= wait_load;
            else if (state == WAIT) wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opl_din  <= '0;
            opl_addr <= 1'b0;
        end else if (pop) begin
            opl_din  <= head.din;
            opl_addr <= head.addr;
        end
    end

`ifdef JTOPL_WRQ_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  ovf_q <= 1'b0;
        else if (flush)           ovf_q <= 1'b0;
        else if (host_wr && full) ovf_q <= 1'b1;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_jtopl_wrq.sv
// Self-checking bench for jtopl_wrq: vector table plus a strobe scoreboard.
module tb_jtopl_wrq;

    localparam int AW = 4;
`ifdef JTOPL_WRQ_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cen = 1'b0;
    logic [7:0]  host_din = '0;
    logic        host_addr = 1'b0;
    logic        host_wr = 1'b0;
    logic        flush = 1'b0;
    logic        full, empty, busy, ovf;
    logic [AW:0] level;
    logic [7:0]  opl_din;
    logic        opl_addr, opl_cs_n, opl_wr_n;

    jtopl_wrq #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .cen(cen), .host_din(host_din), .host_addr(host_addr),
        .host_wr(host_wr), .flush(flush), .full(full), .empty(empty), .level(level),
        .busy(busy), .ovf(ovf), .opl_din(opl_din), .opl_addr(opl_addr),
        .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    int   strobe_cnt = 0, strobe_cyc = 0, strobe_pulse = 0;
    int   strobe_len = 0, low_run = 0, cen_pulses = 0;
    logic prev_cs = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Scoreboard: every strobe must present the oldest expected entry.
    always @(negedge clk) begin
        if (cen && !rst) cen_pulses++;
        if (!opl_cs_n) begin
            if (prev_cs) begin
                strobe_cnt++;
                strobe_cyc   = cyc;
                strobe_pulse = cen_pulses;
                low_run      = 0;
                chk("strobe_wr_n", opl_wr_n, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL strobe_unexpected: got %0h, want no strobe", {opl_addr, opl_din});
                end else begin
                    chk("strobe_entry", {opl_addr, opl_din}, exp_q.pop_front());
                end
            end
            low_run++;
        end else if (!prev_cs) begin
            strobe_len = low_run;
        end
        prev_cs = opl_cs_n;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic a, input logic [7:0] d, input bit acc);
        host_wr = 1'b1; host_addr = a; host_din = d;
        if (acc) exp_q.push_back({a, d});
        step();
        host_wr = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int budget, input string nm);
        int k = 0;
        while (strobe_cnt < target && k < budget) begin step(); k++; end
        if (strobe_cnt < target) timeout(nm);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin step(); k++; end
        if (busy || exp_q.size() != 0) timeout(nm);
    endtask

    typedef struct {
        logic       wr;
        logic       a;
        logic [7:0] d;
        logic [4:0] lvl;
        logic       full;
        logic       empty;
    } vec_t;
    vec_t tbl[18];

    initial begin
        int base, p, s1, s2, k, first_pulse, model_lvl;
        #1 rst = 1'b1;
        #11;
        chk("rst_full", full, 0);       chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);     chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);         chk("rst_opl_din", opl_din, 0);
        chk("rst_opl_addr", opl_addr, 0);
        chk("rst_cs_n", opl_cs_n, 1);   chk("rst_wr_n", opl_wr_n, 1);
        step();
        rst = 1'b0;
        cen = 1'b1;
        step();

        // Address then data write, cen tied high
        base = strobe_cnt; p = cyc;
        push(1'b0, 8'h20, 1); push(1'b1, 8'h21, 1);
        wait_strobes(base + 1, 20, "A_first_strobe");
        chk("A_latency", strobe_cyc - p, 2);
        s1 = strobe_cyc;
        step();
        chk("A_strobe_1clk", opl_cs_n, 1);
        wait_strobes(base + 2, 40, "A_second_strobe");
        chk("A_addr_data_gap", strobe_cyc - s1, 13);
        s2 = strobe_cyc;
        k = 0;
        while (busy && k < 200) begin step(); k++; end
        if (busy) timeout("A_busy_fall");
        else chk("A_busy_fall", cyc - s2, 85);

        // Reset in the middle of a data wait
        base = strobe_cnt;
        push(1'b1, 8'h5A, 1);
        wait_strobes(base + 1, 20, "R_strobe");
        repeat (6) step();
        chk("R_busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("R_cs_n", opl_cs_n, 1);   chk("R_wr_n", opl_wr_n, 1);
        chk("R_busy", busy, 0);       chk("R_opl_din", opl_din, 0);
        chk("R_opl_addr", opl_addr, 0);
        chk("R_level", level, 0);     chk("R_empty", empty, 1);
        chk("R_ovf", ovf, 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
        base = strobe_cnt; p = cyc;
        push(1'b0, 8'h77, 1);
        wait_strobes(base + 1, 20, "R_new_strobe");
        chk("R_latency", strobe_cyc - p, 2);
        wait_idle(100, "R_idle");

        // cen at one pulse in four
        base = strobe_cnt;
        cen = 1'b0;
        push(1'b0, 8'hA0, 1); push(1'b0, 8'hA1, 1);
        first_pulse = -1;
        k = 0;
        while (strobe_cnt < base + 2 && k < 400) begin
            cen = (k % 4 == 0);
            step();
            if (strobe_cnt == base + 1 && first_pulse < 0) first_pulse = strobe_pulse;
            k++;
        end
        if (strobe_cnt < base + 2) timeout("C_second_strobe");
        else begin
            chk("C_strobe_len", strobe_len, 4);
            chk("C_cen_gap", strobe_pulse - first_pulse, 13);
        end
        k = 0;
        while (busy && k < 400) begin cen = (k % 4 == 0); step(); k++; end
        if (busy) timeout("C_idle");
        cen = 1'b1;
        step();

        // Fill past capacity with the pacer stalled
        for (int i = 0; i < 17; i++)
            tbl[i] = '{1'b1, i[0], 8'(8'h40 + i), 5'((i < 16) ? i + 1 : 16), (i >= 15), 1'b0};
        tbl[17] = '{1'b0, 1'b0, 8'h00, 5'd16, 1'b1, 1'b0};
        cen = 1'b0;
        model_lvl = 0;
        base = strobe_cnt;
        for (int i = 0; i < 18; i++) begin
            host_wr = tbl[i].wr; host_addr = tbl[i].a; host_din = tbl[i].d;
            if (tbl[i].wr && model_lvl < 16) begin
                exp_q.push_back({tbl[i].a, tbl[i].d});
                model_lvl++;
            end
            step();
            host_wr = 1'b0;
            chk($sformatf("F_level[%0d]", i), level, tbl[i].lvl);
            chk($sformatf("F_full[%0d]", i), full, tbl[i].full);
            chk($sformatf("F_empty[%0d]", i), empty, tbl[i].empty);
        end
        chk("F_ovf", ovf, OVF_EXP);
        host_wr = 1'b1; host_addr = 1'b1; host_din = 8'hEE;
        cen = 1'b1;
        step();
        host_wr = 1'b0;
        chk("F_drop_with_pop", level, 15);
        wait_idle(2500, "F_drain");
        chk("F_strobe_count", strobe_cnt - base, 16);

        // Flush during the strobe of entry 0
        cen = 1'b0;
        for (int i = 0; i < 7; i++) push(1'b0, 8'(8'h60 + i), 1);
        chk("FL_level7", level, 7);
        base = strobe_cnt;
        cen = 1'b1;
        step();
        chk("FL_strobe_started", strobe_cnt - base, 1);
        chk("FL_level6", level, 6);
        flush = 1'b1;
        exp_q.delete();
        step();
        flush = 1'b0;
        chk("FL_level0", level, 0);
        chk("FL_empty", empty, 1);
        chk("FL_ovf", ovf, 0);
        chk("FL_busy_in_wait", busy, 1);
        k = 0;
        while (busy && k < 100) begin step(); k++; end
        if (busy) timeout("FL_wait");
        else chk("FL_wait_completes", cyc - strobe_cyc, 13);
        repeat (100) step();
        chk("FL_no_more_strobes", strobe_cnt - base, 1);

        // Push coinciding with pop at level 3, 40 pushes across pointer wrap
        cen = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b0, 8'(8'h80 + i), 1);
        chk("W_level3", level, 3);
        host_wr = 1'b1; host_addr = 1'b0; host_din = 8'h83;
        exp_q.push_back({1'b0, 8'h83});
        cen = 1'b1;
        step();
        host_wr = 1'b0;
        chk("W_pushpop_level", level, 3);
        for (int j = 0; j < 36; j++) begin
            k = 0;
            while (cyc < strobe_cyc + 12 && k < 50) begin step(); k++; end
            host_wr = 1'b1; host_addr = 1'b0; host_din = 8'(8'h84 + j);
            exp_q.push_back({1'b0, 8'(8'h84 + j)});
            step();
            host_wr = 1'b0;
            chk($sformatf("W_level[%0d]", j), level, 3);
        end
        wait_idle(200, "W_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
